// File: rtl/lifo_drain.sv
// Pops a LIFO stack (fixed burst or until empty) into a 2-entry buffer drained over valid/ready.
// Zero-latency pop-to-buffer; stalls pops when the buffer is full, on a push collision, or on abort.

module lifo_drain_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

module lifo_drain #(
  parameter int DWIDTH = 5,
  parameter int CWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CWIDTH-1:0] burst_len,
  input  logic              abort,
  input  logic              stk_empty,
  input  logic [DWIDTH-1:0] stk_dout,
  input  logic              stk_wen,
  output logic              stk_ren,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [CWIDTH-1:0] popped_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_FLUSH, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CWIDTH-1:0] r_remaining;
  logic              r_until_empty;
  logic [CWIDTH-1:0] r_popped_cnt;
  logic              r_underrun;

  logic              w_ren;
  logic              w_set_underrun;
  logic              w_start_acc;
  logic              w_accept;
  logic              w_full;
  logic [1:0]        w_count;
  logic [DWIDTH-1:0] w_head;

  lifo_drain_fifo #(
    .W     (DWIDTH),
    .DEPTH (2)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_ren),
    .i_push_dat (stk_dout),
    .i_pop      (w_accept),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full)
  );

  assign m_valid     = (w_count != 2'd0);
  assign m_data      = w_head;
  assign w_accept    = m_valid & m_ready;
  assign w_start_acc = (r_state == S_IDLE) & start;
  assign stk_ren     = w_ren;
  assign underrun    = r_underrun;
  assign popped_cnt  = r_popped_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A push into the stack this cycle masks the pop, and an empty stack with a
  // pending push keeps us in POP so the freshly pushed word still gets drained.
  always_comb begin
    w_state_nxt    = r_state;
    w_ren          = 1'b0;
    w_set_underrun = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_POP;
      end
      S_POP: begin
        busy  = 1'b1;
        w_ren = ~stk_empty & ~stk_wen & ~w_full & ~abort;
        if (abort) begin
          w_state_nxt = S_FLUSH;
        end else if (w_ren & ~r_until_empty & (r_remaining == CWIDTH'(1))) begin
          w_state_nxt = S_FLUSH;
        end else if (stk_empty & ~stk_wen) begin
          w_state_nxt    = S_FLUSH;
          w_set_underrun = ~r_until_empty & (r_remaining != '0);
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if ((w_count == 2'd0) || ((w_count == 2'd1) & w_accept)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining   <= '0;
      r_until_empty <= 1'b0;
      r_popped_cnt  <= '0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_remaining   <= burst_len;
        r_until_empty <= (burst_len == '0);
        r_popped_cnt  <= '0;
        r_underrun    <= 1'b0;
      end
      if (w_ren) begin
        if (r_popped_cnt != '1) r_popped_cnt <= r_popped_cnt + 1'b1;
        if (~r_until_empty && (r_remaining != '0)) r_remaining <= r_remaining - 1'b1;
      end
      if (w_set_underrun) r_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lifo_drain.sv
// Directed bench for lifo_drain: behavioural stack model, per-scenario tasks with inline checks.

module tb_lifo_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] burst_len;
  logic       abort;
  logic       stk_empty;
  logic [4:0] stk_dout;
  logic       stk_wen;
  logic       stk_ren;
  logic       m_valid;
  logic [4:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic       underrun;
  logic [4:0] popped_cnt;

  logic [4:0] push_dat;
  logic [4:0] stk_mem [0:31];
  int         stk_sp;
  logic [4:0] out_log [0:15];
  int         n_out, n_ren, n_done, n_collide;
  logic       s_ren, s_vld, s_done, s_busy, s_wen;
  logic [4:0] s_dat;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  assign stk_empty = (stk_sp == 0);
  assign stk_dout  = (stk_sp == 0) ? 5'd0 : stk_mem[5'(stk_sp - 1)];

  lifo_drain #(.DWIDTH(5), .CWIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .stk_empty  (stk_empty),
    .stk_dout   (stk_dout),
    .stk_wen    (stk_wen),
    .stk_ren    (stk_ren),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .popped_cnt (popped_cnt)
  );

  // One clock cycle: sample just after the falling edge, then update the stack model after the rising edge.
  task automatic step();
    #1;
    s_ren  = stk_ren;
    s_wen  = stk_wen;
    s_vld  = m_valid;
    s_dat  = m_data;
    s_done = done;
    s_busy = busy;
    if (stk_ren && stk_wen) n_collide++;
    if (stk_ren) n_ren++;
    if (done) n_done++;
    if (m_valid && m_ready) begin
      if (n_out < 16) out_log[4'(n_out)] = m_data;
      n_out++;
    end
    @(posedge clk);
    #1;
    if (s_wen) begin
      stk_mem[5'(stk_sp)] = push_dat;
      stk_sp++;
    end else if (s_ren && stk_sp > 0) begin
      stk_sp--;
    end
    @(negedge clk);
  endtask

  task automatic clear_counts();
    n_out = 0; n_ren = 0; n_done = 0; n_collide = 0;
  endtask

  task automatic stk_push(input logic [4:0] v);
    stk_mem[5'(stk_sp)] = v;
    stk_sp++;
  endtask

  task automatic run_drain(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (s_done) seen = 1'b1;
    end
    step();
    step();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({stk_ren, m_valid, m_data, busy, done, underrun, popped_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ren=%b vld=%b dat=%h busy=%b done=%b udr=%b cnt=%h, all expected 0",
               stk_ren, m_valid, m_data, busy, done, underrun, popped_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (s_busy !== 1'b0 || s_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b ren=%b expected 0 0", s_busy, s_ren);
    end
  endtask

  task automatic test_burst();
    clear_counts();
    stk_sp = 0;
    stk_push(5'h11); stk_push(5'h12); stk_push(5'h13);
    m_ready = 1'b1; burst_len = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    run_drain(20, "burst");
    n_tests++;
    if (n_ren !== 2) begin n_fail++; $display("FAIL burst_pops: got %0d expected 2", n_ren); end
    n_tests++;
    if (n_out !== 2 || out_log[0] !== 5'h13 || out_log[1] !== 5'h12) begin
      n_fail++;
      $display("FAIL burst_order: got n=%0d %h %h expected n=2 13 12", n_out, out_log[0], out_log[1]);
    end
    n_tests++;
    if (popped_cnt !== 5'd2 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_status: got cnt=%0d udr=%b expected 2 0", popped_cnt, underrun);
    end
    n_tests++;
    if (n_done !== 1) begin n_fail++; $display("FAIL burst_done_pulses: got %0d expected 1", n_done); end
    n_tests++;
    if (stk_sp !== 1 || stk_mem[0] !== 5'h11) begin
      n_fail++;
      $display("FAIL burst_stack_left: got sp=%0d top=%h expected 1 11", stk_sp, stk_mem[0]);
    end
  endtask

  task automatic test_underrun();
    clear_counts();
    stk_sp = 0;
    stk_push(5'h05); stk_push(5'h06);
    m_ready = 1'b1; burst_len = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    run_drain(20, "underrun");
    n_tests++;
    if (n_ren !== 2 || popped_cnt !== 5'd2) begin
      n_fail++;
      $display("FAIL underrun_pops: got ren=%0d cnt=%0d expected 2 2", n_ren, popped_cnt);
    end
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b expected 1", underrun); end
    n_tests++;
    if (busy !== 1'b0 || n_done !== 1) begin
      n_fail++;
      $display("FAIL underrun_end: got busy=%b dones=%0d expected 0 1", busy, n_done);
    end
    n_tests++;
    if (out_log[0] !== 5'h06 || out_log[1] !== 5'h05) begin
      n_fail++;
      $display("FAIL underrun_order: got %h %h expected 06 05", out_log[0], out_log[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_d [4];
    bit unstable = 1'b0;
    exp_d = '{5'h04, 5'h03, 5'h02, 5'h01};
    clear_counts();
    stk_sp = 0;
    stk_push(5'h01); stk_push(5'h02); stk_push(5'h03); stk_push(5'h04);
    m_ready = 1'b0; burst_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL bp_underrun_cleared: got %b expected 0", underrun); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_vld && s_dat !== 5'h04) unstable = 1'b1;
    end
    n_tests++;
    if (n_ren !== 2 || s_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: got pops=%0d ren=%b expected 2 0", n_ren, s_ren);
    end
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== 5'h04 || unstable) begin
      n_fail++;
      $display("FAIL bp_hold: got vld=%b dat=%h unstable=%b expected 1 04 0", m_valid, m_data, unstable);
    end
    m_ready = 1'b1;
    run_drain(20, "bp");
    n_tests++;
    if (n_out !== 4 || n_ren !== 4 || popped_cnt !== 5'd4) begin
      n_fail++;
      $display("FAIL bp_counts: got out=%0d pops=%0d cnt=%0d expected 4 4 4", n_out, n_ren, popped_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_log[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h expected %h", i, out_log[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_collision();
    clear_counts();
    stk_sp = 0;
    stk_push(5'h07); stk_push(5'h08);
    m_ready = 1'b1; burst_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    stk_wen = 1'b1; push_dat = 5'h1A;
    step();
    n_tests++;
    if (s_ren !== 1'b0) begin n_fail++; $display("FAIL coll_blocked: got ren=%b expected 0", s_ren); end
    stk_wen = 1'b0;
    run_drain(20, "coll");
    n_tests++;
    if (n_collide !== 0) begin n_fail++; $display("FAIL coll_overlap: got %0d cycles expected 0", n_collide); end
    n_tests++;
    if (n_out !== 3 || out_log[0] !== 5'h1A || out_log[1] !== 5'h08 || out_log[2] !== 5'h07) begin
      n_fail++;
      $display("FAIL coll_order: got n=%0d %h %h %h expected n=3 1a 08 07", n_out, out_log[0], out_log[1], out_log[2]);
    end
    n_tests++;
    if (popped_cnt !== 5'd3 || stk_sp !== 0) begin
      n_fail++;
      $display("FAIL coll_counts: got cnt=%0d sp=%0d expected 3 0", popped_cnt, stk_sp);
    end
  endtask

  task automatic test_empty_wait();
    clear_counts();
    stk_sp = 0;
    m_ready = 1'b1; burst_len = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    stk_wen = 1'b1; push_dat = 5'h0F;
    step();
    stk_wen = 1'b0;
    n_tests++;
    if (s_ren !== 1'b0 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_cycle: got ren=%b busy=%b expected 0 1", s_ren, s_busy);
    end
    run_drain(20, "wait");
    n_tests++;
    if (n_out !== 1 || out_log[0] !== 5'h0F || underrun !== 1'b0 || popped_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL wait_result: got n=%0d dat=%h udr=%b cnt=%0d expected 1 0f 0 1",
               n_out, out_log[0], underrun, popped_cnt);
    end
  endtask

  task automatic test_abort();
    clear_counts();
    stk_sp = 0;
    stk_push(5'h15); stk_push(5'h16); stk_push(5'h17); stk_push(5'h18); stk_push(5'h19);
    m_ready = 1'b0; burst_len = 5'd4; start = 1'b1;
    step();
    burst_len = 5'd9;
    step();
    abort = 1'b1;
    step();
    n_tests++;
    if (s_ren !== 1'b0) begin n_fail++; $display("FAIL abort_ren: got %b expected 0", s_ren); end
    abort = 1'b0;
    step();
    n_tests++;
    if (s_busy !== 1'b1 || s_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flush: got busy=%b ren=%b expected 1 0", s_busy, s_ren);
    end
    start = 1'b0; m_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    n_tests++;
    if (s_done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b expected 1", s_done); end
    start = 1'b0;
    step();
    n_tests++;
    if (s_busy !== 1'b0 || s_ren !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start_in_done: got busy=%b ren=%b expected 0 0", s_busy, s_ren);
    end
    n_tests++;
    if (popped_cnt !== 5'd1 || underrun !== 1'b0 || n_ren !== 1 || stk_sp !== 4) begin
      n_fail++;
      $display("FAIL abort_counts: got cnt=%0d udr=%b pops=%0d sp=%0d expected 1 0 1 4",
               popped_cnt, underrun, n_ren, stk_sp);
    end
    n_tests++;
    if (n_out !== 1 || out_log[0] !== 5'h19 || n_done !== 1) begin
      n_fail++;
      $display("FAIL abort_output: got n=%0d dat=%h dones=%0d expected 1 19 1", n_out, out_log[0], n_done);
    end
    burst_len = 5'd0;
  endtask

  task automatic test_reset_mid();
    clear_counts();
    stk_sp = 0;
    stk_push(5'h0A); stk_push(5'h0B); stk_push(5'h0C);
    m_ready = 1'b0; burst_len = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_tests++;
    if (m_valid !== 1'b1 || popped_cnt !== 5'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got vld=%b cnt=%0d busy=%b expected 1 1 1", m_valid, popped_cnt, busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({stk_ren, m_valid, m_data, busy, done, underrun, popped_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL rmid_async: got ren=%b vld=%b dat=%h busy=%b done=%b udr=%b cnt=%h, all expected 0",
               stk_ren, m_valid, m_data, busy, done, underrun, popped_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if (n_ren !== 0 || s_busy !== 1'b0 || stk_sp !== 2) begin
      n_fail++;
      $display("FAIL rmid_after: got pops=%0d busy=%b sp=%0d expected 0 0 2", n_ren, s_busy, stk_sp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = 5'd0; abort = 1'b0;
    stk_wen = 1'b0; push_dat = 5'd0; m_ready = 1'b0; stk_sp = 0;
    clear_counts();
    test_reset();
    test_burst();
    test_underrun();
    test_backpressure();
    test_collision();
    test_empty_wait();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_drain.md
Name: lifo_drain

Overview:
Drain controller directly downstream of the LIFO stack. On a start pulse it pops the stack, either a fixed burst or until empty, by driving the stack's read enable. Each popped word goes into a 2-entry output buffer presented on a valid/ready stream to the consumer. It never issues a read enable in a cycle where the upstream writer pushes, so the stack never sees simultaneous read and write.

Parameters:
DWIDTH, 5, width of stack data word and output stream data
CWIDTH, 5, width of burst_len and popped_cnt (max burst 2**CWIDTH-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  single-cycle request to begin a drain; ignored while busy=1
burst_len  in  CWIDTH  words to pop, sampled on accepted start; 0 = drain until empty
abort  in  1  terminate popping early; buffered words still flushed
stk_empty  in  1  stack empty flag
stk_dout  in  DWIDTH  stack top-of-stack data, valid same cycle as stk_ren
stk_wen  in  1  upstream push into the stack this cycle
stk_ren  out  1  pop request to stack (combinational)
m_valid  out  1  output word available
m_data  out  DWIDTH  output word (head of buffer)
m_ready  in  1  consumer accepts word when m_valid & m_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of drain
underrun  out  1  burst ended early on empty stack; held until next accepted start
popped_cnt  out  CWIDTH  words popped in current/last drain; saturates at all-ones

Behaviour:
- Reset (rst=0, async): state IDLE; buffer count 0; stk_ren, m_valid, busy, done, underrun = 0; m_data, popped_cnt = 0.
- States: IDLE, POP, FLUSH, DONE. busy=1 in POP and FLUSH, 0 in IDLE and DONE.
- IDLE: start=1 -> POP next edge; latch remaining=burst_len and mode (until-empty if burst_len=0); clear popped_cnt and underrun.
- POP: stk_ren = ~stk_empty & ~stk_wen & (count<2) & ~abort.
- On each edge with stk_ren=1: stk_dout written to the buffer tail (zero latency, since stack data is combinational); popped_cnt+1 (saturating); remaining-1 in burst mode.
- POP exits to FLUSH (all evaluated on the current cycle):
  - abort=1.
  - Burst mode and the pop this cycle makes remaining 0.
  - stk_empty=1 & stk_wen=0. In burst mode with remaining>0 this also sets underrun=1.
  - stk_empty=1 with stk_wen=1 stays in POP and waits.
- FLUSH: no pops; go to DONE when count=0, or when count=1 and the head is accepted this cycle.
- DONE: done=1 for exactly one cycle -> IDLE. A start during DONE is ignored.
- Buffer: 2-entry FIFO.
  - m_valid = (count!=0); m_data = head entry.
  - Simultaneous push and accept at count=1 keeps count=1, with the new word as head.
  - Words leave in pop order, i.e. LIFO order relative to stack pushes.
  - m_data holds stable while m_valid & ~m_ready.
- stk_wen=1 blocks the pop only in that cycle; the pop resumes the next cycle on the new top of stack.
- Counters wrap nowhere: remaining only decrements when >0; popped_cnt saturates.

Test Plan:
- Reset mid-drain: stack holds 3 words, start with burst_len=0, assert rst=0 after 1 pop -> all outputs 0 immediately (async), state IDLE; after release, stk_ren=0 until next start.
- Burst drain: stack holds 0x11,0x12,0x13 (pushed in order), burst_len=2, m_ready=1 -> stk_ren high 2 cycles; m_data 0x13 then 0x12; popped_cnt=2, underrun=0, done pulse once; stack keeps 0x11.
- Underrun: stack holds 2 words, burst_len=5 -> 2 pops, underrun=1, popped_cnt=2, done asserted, busy drops.
- Backpressure: stack holds 4 words, burst_len=0, m_ready=0 -> exactly 2 pops then stk_ren=0, m_valid=1, m_data stable; raise m_ready -> remaining 2 words drained in order, done after last accept.
- Write collision: during POP, assert stk_wen=1 with data 0x1A for one cycle -> stk_ren=0 that cycle; next cycle pops 0x1A first; stk_ren & stk_wen never both 1.
- Abort and ignored start: abort after 1 pop with burst_len=4 -> FLUSH, popped_cnt=1, underrun=0, done after buffered word accepted; start pulses while busy have no effect.
